// File: rtl/axi_burst_pkg.sv
// axi_burst_pkg: shared types and helpers for the AXI4 burst write master.
// Holds the FSM state enum, AXI encodings and the 4KB-crossing check.
package axi_burst_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_REJECT
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // True when a burst of len+1 beats of 'bytes' each runs past the 4KB page.
    function automatic logic crosses_4k(
        input logic [11:0] off,
        input logic [7:0]  len,
        input int unsigned bytes
    );
        return (32'(off) + (32'(len) + 32'd1) * bytes) > 32'd4096;
    endfunction

endpackage

// File: rtl/axi_wbeat_skid.sv
// axi_wbeat_skid: one-entry registered W output stage with beat counter.
// Ports: clr_i/en_i/len_i control, in_* beat stream, w*_o AXI W, last_hs_o.
module axi_wbeat_skid #(
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic [7:0]             len_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_BITS-1:0]   in_data_i,
    input  logic [DATA_BITS/8-1:0] in_strb_i,
    output logic                   wvalid_o,
    output logic [DATA_BITS-1:0]   wdata_o,
    output logic [DATA_BITS/8-1:0] wstrb_o,
    output logic                   wlast_o,
    input  logic                   wready_i,
    output logic                   last_hs_o
);

    logic                   full_q;
    logic                   wlast_q;
    logic                   all_q;
    logic [7:0]             cnt_q;
    logic [DATA_BITS-1:0]   data_q;
    logic [DATA_BITS/8-1:0] strb_q;
    logic                   load;
    logic                   drain;

    assign drain      = full_q && wready_i;
    // Refill in the same cycle the held beat drains: sustains 1 beat/cycle.
    assign in_ready_o = en_i && !all_q && (!full_q || wready_i);
    assign load       = in_valid_i && in_ready_o;
    assign last_hs_o  = drain && wlast_q;

    assign wvalid_o = full_q;
    assign wdata_o  = data_q;
    assign wstrb_o  = strb_q;
    assign wlast_o  = wlast_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q  <= 1'b0;
            wlast_q <= 1'b0;
            all_q   <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else if (clr_i) begin
            full_q  <= 1'b0;
            wlast_q <= 1'b0;
            all_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            full_q  <= 1'b1;
            data_q  <= in_data_i;
            strb_q  <= in_strb_i;
            wlast_q <= (cnt_q == len_i);
            all_q   <= (cnt_q == len_i);
            cnt_q   <= cnt_q + 8'd1;
        end else if (drain) begin
            full_q  <= 1'b0;
            wlast_q <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_master_write_burst.sv
// axi_master_write_burst: turns one request into one AXI4 INCR write burst.
// Ports: req_* request, dat_* beat stream, done/resp report, AXI AW/W/B master.
module axi_master_write_burst
    import axi_burst_pkg::*;
#(
    parameter int unsigned ID_BITS   = 4,
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned MASTER_ID = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_BITS-1:0]   req_addr,
    input  logic [7:0]             req_len,
    input  logic                   dat_valid,
    output logic                   dat_ready,
    input  logic [DATA_BITS-1:0]   dat_data,
    input  logic [DATA_BITS/8-1:0] dat_strb,
    output logic                   done,
    output logic [1:0]             resp,
    output logic [ID_BITS-1:0]     AWID,
    output logic [ADDR_BITS-1:0]   AWADDR,
    output logic [7:0]             AWLEN,
    output logic [2:0]             AWSIZE,
    output logic [1:0]             AWBURST,
    output logic                   AWVALID,
    input  logic                   AWREADY,
    output logic [DATA_BITS-1:0]   WDATA,
    output logic [DATA_BITS/8-1:0] WSTRB,
    output logic                   WLAST,
    output logic                   WVALID,
    input  logic                   WREADY,
    input  logic [ID_BITS-1:0]     BID,
    input  logic [1:0]             BRESP,
    input  logic                   BVALID,
    output logic                   BREADY
);

    localparam int unsigned BYTES = DATA_BITS / 8;
    localparam logic [2:0]  SIZE  = 3'($clog2(BYTES));
    localparam logic [ID_BITS-1:0] MID = ID_BITS'(MASTER_ID);

    state_e                 state_q;
    logic                   req_ready_q;
    logic                   done_q;
    logic [1:0]             resp_q;
    logic [7:0]             len_q;
    logic [ID_BITS-1:0]     awid_q;
    logic [ADDR_BITS-1:0]   awaddr_q;
    logic [7:0]             awlen_q;
    logic [2:0]             awsize_q;
    logic [1:0]             awburst_q;
    logic                   awvalid_q;
    logic                   bready_q;

    logic accept;
    logic reject_d;
    logic w_en;
    logic last_hs;
    logic b_ok;

    assign accept   = req_valid && req_ready_q;
    assign reject_d = (32'(req_len) + 32'd1 > MAX_BEATS)
                   || crosses_4k(req_addr[11:0], req_len, BYTES);
    // The first beat may load during the AW handshake cycle; it only
    // appears on W from the following cycle.
    assign w_en     = (state_q == S_ADDR && AWREADY) || (state_q == S_DATA);
    assign b_ok     = BVALID && (BID == MID);

    assign req_ready = req_ready_q;
    assign done      = done_q;
    assign resp      = resp_q;
    assign AWID      = awid_q;
    assign AWADDR    = awaddr_q;
    assign AWLEN     = awlen_q;
    assign AWSIZE    = awsize_q;
    assign AWBURST   = awburst_q;
    assign AWVALID   = awvalid_q;
    assign BREADY    = bready_q;

    axi_wbeat_skid #(
        .DATA_BITS (DATA_BITS)
    ) u_skid (
        .clk        (clk),
        .rst_ni     (rst),
        .clr_i      (accept),
        .en_i       (w_en),
        .len_i      (len_q),
        .in_valid_i (dat_valid),
        .in_ready_o (dat_ready),
        .in_data_i  (dat_data),
        .in_strb_i  (dat_strb),
        .wvalid_o   (WVALID),
        .wdata_o    (WDATA),
        .wstrb_o    (WSTRB),
        .wlast_o    (WLAST),
        .wready_i   (WREADY),
        .last_hs_o  (last_hs)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            done_q      <= 1'b0;
            resp_q      <= '0;
            len_q       <= '0;
            awid_q      <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awsize_q    <= '0;
            awburst_q   <= '0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        len_q       <= req_len;
                        if (reject_d) begin
                            state_q <= S_REJECT;
                            done_q  <= 1'b1;
                            resp_q  <= AXI_RESP_SLVERR;
                        end else begin
                            state_q   <= S_ADDR;
                            awvalid_q <= 1'b1;
                            awaddr_q  <= req_addr;
                            awlen_q   <= req_len;
                            awid_q    <= MID;
                            awsize_q  <= SIZE;
                            awburst_q <= AXI_BURST_INCR;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_REJECT: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                S_ADDR: begin
                    if (AWREADY) begin
                        awvalid_q <= 1'b0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (last_hs) begin
                        state_q  <= S_RESP;
                        bready_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    // A response carrying another ID is consumed and dropped.
                    if (b_ok) begin
                        bready_q    <= 1'b0;
                        resp_q      <= BRESP;
                        done_q      <= 1'b1;
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master_write_burst.sv
// tb_axi_master_write_burst: directed self-checking bench for the burst master.
// Behavioural slave and beat source, one task per scenario.
module tb_axi_master_write_burst;

    localparam int ID_BITS = 4;
    localparam int ADDR_BITS = 32;
    localparam int DATA_BITS = 32;

    logic clk, rst;
    logic req_valid, req_ready;
    logic [31:0] req_addr;
    logic [7:0] req_len;
    logic dat_valid, dat_ready;
    logic [31:0] dat_data;
    logic [3:0] dat_strb;
    logic done;
    logic [1:0] resp;
    logic [3:0] AWID;
    logic [31:0] AWADDR;
    logic [7:0] AWLEN;
    logic [2:0] AWSIZE;
    logic [1:0] AWBURST;
    logic AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic [3:0] WSTRB;
    logic WLAST, WVALID, WREADY;
    logic [3:0] BID;
    logic [1:0] BRESP;
    logic BVALID, BREADY;

    axi_master_write_burst #(
        .ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
        .MAX_BEATS(16), .MASTER_ID(0)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .dat_valid(dat_valid), .dat_ready(dat_ready),
        .dat_data(dat_data), .dat_strb(dat_strb),
        .done(done), .resp(resp),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model / recorder state
    int cyc = 0;
    logic [31:0] src_d[$];
    logic [3:0]  src_s[$];
    int src_idx;
    bit src_gap, w_toggle, b_wrong_first;
    int aw_delay, aw_wait;
    logic [1:0] b_resp;
    int b_stage, b_hs_n;
    logic [31:0] got_d[$];
    logic [3:0]  got_s[$];
    bit got_l[$];
    int aw_cnt, aw_first, aw_hs_cyc, w_first, wlast_cyc, b_hs_cyc;
    int acc_cyc, done_cnt, done_cyc;
    logic [1:0] done_resp;
    logic [31:0] aw_addr;
    logic [7:0] aw_len;
    logic [2:0] aw_size;
    logic [1:0] aw_burst;
    logic [3:0] aw_id;
    int aw_unstable, w_unstable, w_early;
    bit aw_stall, w_stall;
    logic [31:0] p_awaddr, p_wdata;
    logic [7:0] p_awlen;
    logic [3:0] p_wstrb;
    logic p_wlast;

    task automatic clear_model();
        src_d.delete(); src_s.delete(); got_d.delete(); got_s.delete(); got_l.delete();
        src_idx = 0; src_gap = 0; w_toggle = 0; b_wrong_first = 0;
        aw_delay = 0; aw_wait = 0; b_resp = 2'b00; b_stage = 0; b_hs_n = 0;
        aw_cnt = 0; aw_first = -1; aw_hs_cyc = -1; w_first = -1; wlast_cyc = -1;
        b_hs_cyc = -1; acc_cyc = -1; done_cnt = 0; done_cyc = -1; done_resp = 2'bxx;
        aw_unstable = 0; w_unstable = 0; w_early = 0; aw_stall = 0; w_stall = 0;
    endtask

    // One clock of slave + source behaviour, entered and left at a negedge.
    task automatic step();
        bit acc;
        if (done) begin done_cnt++; done_cyc = cyc; done_resp = resp; end
        if (AWVALID && aw_first < 0) aw_first = cyc;
        if (WVALID && w_first < 0) w_first = cyc;
        if (WVALID && aw_cnt == 0) w_early++;
        if (aw_stall && (AWVALID !== 1'b1 || AWADDR !== p_awaddr || AWLEN !== p_awlen))
            aw_unstable++;
        if (w_stall && (WVALID !== 1'b1 || WDATA !== p_wdata || WSTRB !== p_wstrb
                        || WLAST !== p_wlast))
            w_unstable++;
        if (AWVALID) aw_wait++;
        AWREADY = AWVALID && (aw_wait > aw_delay);
        WREADY = w_toggle ? cyc[0] : 1'b1;
        dat_valid = (src_idx < src_d.size()) && (!src_gap || (cyc % 3) != 1);
        if (src_idx < src_d.size()) begin
            dat_data = src_d[src_idx]; dat_strb = src_s[src_idx];
        end else begin
            dat_data = '0; dat_strb = '0;
        end
        BVALID = (b_stage == 1) || (b_stage == 2);
        BID = (b_stage == 1) ? 4'h5 : 4'h0;
        BRESP = (b_stage == 2) ? b_resp : 2'b00;
        #1;
        acc = req_valid && req_ready;
        if (acc) acc_cyc = cyc;
        if (AWVALID && AWREADY) begin
            aw_cnt++; aw_hs_cyc = cyc; aw_addr = AWADDR; aw_len = AWLEN;
            aw_size = AWSIZE; aw_burst = AWBURST; aw_id = AWID; aw_wait = 0;
        end
        aw_stall = AWVALID && !AWREADY; p_awaddr = AWADDR; p_awlen = AWLEN;
        if (WVALID && WREADY) begin
            got_d.push_back(WDATA); got_s.push_back(WSTRB); got_l.push_back(WLAST);
            if (WLAST) begin wlast_cyc = cyc; b_stage = b_wrong_first ? 1 : 2; end
        end
        w_stall = WVALID && !WREADY;
        p_wdata = WDATA; p_wstrb = WSTRB; p_wlast = WLAST;
        if (dat_valid && dat_ready) src_idx++;
        if (BVALID && BREADY) begin
            b_hs_cyc = cyc; b_hs_n++; b_stage = (b_stage == 1) ? 2 : 3;
        end
        @(negedge clk);
        cyc++;
        if (acc) req_valid = 1'b0;
    endtask

    task automatic start_req(input logic [31:0] a, input logic [7:0] l);
        req_addr = a; req_len = l; req_valid = 1'b1;
    endtask

    task automatic run(input int max);
        for (int k = 0; k < max && done_cnt == 0; k++) step();
        repeat (3) step();
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_addr = '0; req_len = '0; dat_valid = 0; dat_data = '0;
        dat_strb = '0; AWREADY = 0; WREADY = 0; BID = '0; BRESP = '0; BVALID = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        clear_model();
        #3;
        checks++;
        if ({AWVALID, WVALID, BREADY, req_ready, dat_ready, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {AWVALID, WVALID, BREADY, req_ready, dat_ready, done});
        end
        checks++;
        if ({AWID, AWADDR, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB, WLAST, resp} !== '0) begin
            errors++;
            $display("FAIL reset_payload: awaddr=%h awlen=%h wdata=%h resp=%b want 0",
                     AWADDR, AWLEN, WDATA, resp);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_idle_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_single();
        clear_model();
        src_d.push_back(32'hDEADBEEF); src_s.push_back(4'hF);
        start_req(32'h1000, 8'd0);
        run(30);
        checks++;
        if (aw_cnt != 1 || aw_len !== 8'd0 || aw_addr !== 32'h1000) begin
            errors++;
            $display("FAIL single_aw: cnt=%0d len=%h addr=%h want 1/00/1000",
                     aw_cnt, aw_len, aw_addr);
        end
        checks++;
        if (got_d.size() != 1 || got_d[0] !== 32'hDEADBEEF || got_l[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_w: beats=%0d want 1 beat DEADBEEF with WLAST", got_d.size());
        end
        checks++;
        if (w_first != acc_cyc + 2) begin
            errors++; $display("FAIL single_w_lat: got %0d want %0d", w_first, acc_cyc + 2);
        end
        checks++;
        if (done_cnt != 1 || done_resp !== 2'b00 || done_cyc != acc_cyc + 4
            || done_cyc != b_hs_cyc + 1) begin
            errors++;
            $display("FAIL single_done: cnt=%0d resp=%b cyc=%0d want 1/00/%0d",
                     done_cnt, done_resp, done_cyc, acc_cyc + 4);
        end
    endtask

    task automatic test_burst();
        int bad;
        logic [7:0] lv;
        clear_model();
        for (int i = 0; i < 8; i++) begin
            src_d.push_back(32'hA5A50000 + i); src_s.push_back(4'hF);
        end
        start_req(32'h2000, 8'd7);
        run(40);
        checks++;
        if (aw_addr !== 32'h2000 || aw_len !== 8'd7 || aw_size !== 3'd2
            || aw_burst !== 2'b01 || aw_id !== 4'h0) begin
            errors++;
            $display("FAIL burst_aw: addr=%h len=%h size=%h burst=%b id=%h want 2000/07/2/01/0",
                     aw_addr, aw_len, aw_size, aw_burst, aw_id);
        end
        checks++;
        if (got_d.size() != 8) begin
            errors++; $display("FAIL burst_count: got %0d want 8", got_d.size());
        end
        bad = 0; lv = '0;
        for (int i = 0; i < 8 && i < got_d.size(); i++) begin
            if (got_d[i] !== 32'hA5A50000 + i) bad++;
            lv[i] = got_l[i];
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL burst_data: %0d wrong beats want 0", bad);
        end
        checks++;
        if (lv !== 8'h80) begin
            errors++; $display("FAIL burst_wlast: got %b want 10000000", lv);
        end
        checks++;
        if (w_first != acc_cyc + 2 || wlast_cyc != acc_cyc + 9) begin
            errors++;
            $display("FAIL burst_timing: first=%0d last=%0d want %0d/%0d",
                     w_first, wlast_cyc, acc_cyc + 2, acc_cyc + 9);
        end
        checks++;
        if (done_cnt != 1 || done_resp !== 2'b00) begin
            errors++; $display("FAIL burst_done: cnt=%0d resp=%b want 1/00", done_cnt, done_resp);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        logic [3:0] lv;
        logic [3:0] st [4];
        st[0] = 4'h1; st[1] = 4'h3; st[2] = 4'hC; st[3] = 4'hF;
        clear_model();
        for (int i = 0; i < 4; i++) begin
            src_d.push_back(32'h11111111 * (i + 1)); src_s.push_back(st[i]);
        end
        aw_delay = 5; w_toggle = 1; src_gap = 1;
        start_req(32'h3000, 8'd3);
        run(80);
        checks++;
        if (aw_unstable != 0 || aw_hs_cyc != aw_first + 5) begin
            errors++;
            $display("FAIL bp_aw: unstable=%0d hs=%0d want 0/%0d",
                     aw_unstable, aw_hs_cyc, aw_first + 5);
        end
        checks++;
        if (w_unstable != 0) begin
            errors++; $display("FAIL bp_w_hold: got %0d changes want 0", w_unstable);
        end
        checks++;
        if (w_early != 0) begin
            errors++; $display("FAIL bp_w_before_aw: got %0d want 0", w_early);
        end
        checks++;
        if (got_d.size() != 4 || src_idx != 4) begin
            errors++;
            $display("FAIL bp_count: beats=%0d consumed=%0d want 4/4", got_d.size(), src_idx);
        end
        bad = 0; lv = '0;
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            if (got_d[i] !== 32'h11111111 * (i + 1) || got_s[i] !== st[i]) bad++;
            lv[i] = got_l[i];
        end
        checks++;
        if (bad != 0 || lv !== 4'h8) begin
            errors++; $display("FAIL bp_data: bad=%0d wlast=%b want 0/1000", bad, lv);
        end
        checks++;
        if (done_cnt != 1 || done_resp !== 2'b00) begin
            errors++; $display("FAIL bp_done: cnt=%0d resp=%b want 1/00", done_cnt, done_resp);
        end
    endtask

    task automatic test_reject();
        clear_model();
        src_d.push_back(32'h1); src_s.push_back(4'hF);
        start_req(32'h0FF8, 8'd3);
        run(10);
        checks++;
        if (aw_first != -1 || src_idx != 0 || got_d.size() != 0) begin
            errors++;
            $display("FAIL rej4k_bus: awvalid_cyc=%0d consumed=%0d want -1/0", aw_first, src_idx);
        end
        checks++;
        if (done_cnt != 1 || done_resp !== 2'b10 || done_cyc != acc_cyc + 1) begin
            errors++;
            $display("FAIL rej4k_done: cnt=%0d resp=%b cyc=%0d want 1/10/%0d",
                     done_cnt, done_resp, done_cyc, acc_cyc + 1);
        end
        clear_model();
        start_req(32'h3000, 8'd16);
        run(10);
        checks++;
        if (aw_first != -1 || done_cnt != 1 || done_resp !== 2'b10 || done_cyc != acc_cyc + 1) begin
            errors++;
            $display("FAIL rejlen: aw=%0d cnt=%0d resp=%b want -1/1/10", aw_first, done_cnt, done_resp);
        end
        clear_model();
        for (int i = 0; i < 4; i++) begin
            src_d.push_back(32'hC0DE0000 + i); src_s.push_back(4'hF);
        end
        start_req(32'h0FF0, 8'd3);
        run(30);
        checks++;
        if (aw_cnt != 1 || got_d.size() != 4 || done_resp !== 2'b00) begin
            errors++;
            $display("FAIL edge4k_ok: aw=%0d beats=%0d resp=%b want 1/4/00",
                     aw_cnt, got_d.size(), done_resp);
        end
    endtask

    task automatic test_err_resp();
        clear_model();
        src_d.push_back(32'h600D0001); src_s.push_back(4'hF);
        src_d.push_back(32'h600D0002); src_s.push_back(4'hF);
        b_wrong_first = 1; b_resp = 2'b10;
        start_req(32'h6000, 8'd1);
        run(30);
        checks++;
        if (b_hs_n != 2) begin
            errors++; $display("FAIL err_b_hs: got %0d want 2", b_hs_n);
        end
        checks++;
        if (done_cnt != 1 || done_resp !== 2'b10 || done_cyc != b_hs_cyc + 1) begin
            errors++;
            $display("FAIL err_done: cnt=%0d resp=%b cyc=%0d want 1/10/%0d",
                     done_cnt, done_resp, done_cyc, b_hs_cyc + 1);
        end
    endtask

    task automatic test_reset_mid();
        clear_model();
        for (int i = 0; i < 8; i++) begin
            src_d.push_back(32'h40000000 + i); src_s.push_back(4'hF);
        end
        start_req(32'h4000, 8'd7);
        for (int k = 0; k < 40 && got_d.size() < 2; k++) step();
        checks++;
        if (got_d.size() != 2) begin
            errors++; $display("FAIL rstmid_reach: beats=%0d want 2", got_d.size());
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({AWVALID, WVALID, BREADY, req_ready, dat_ready, done} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_async: got %b want 000000",
                     {AWVALID, WVALID, BREADY, req_ready, dat_ready, done});
        end
        checks++;
        if ({AWADDR, AWLEN, WDATA, WLAST} !== '0) begin
            errors++;
            $display("FAIL rstmid_payload: awaddr=%h wdata=%h want 0", AWADDR, WDATA);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        step();
        checks++;
        if (req_ready !== 1'b1 || AWVALID !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle: req_ready=%b awvalid=%b want 1/0", req_ready, AWVALID);
        end
        src_d.push_back(32'h50000001); src_s.push_back(4'h3);
        src_d.push_back(32'h50000002); src_s.push_back(4'hC);
        start_req(32'h5000, 8'd1);
        run(30);
        checks++;
        if (aw_addr !== 32'h5000 || got_d.size() != 2 || done_cnt != 1 || done_resp !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_next: addr=%h beats=%0d done=%0d resp=%b want 5000/2/1/00",
                     aw_addr, got_d.size(), done_cnt, done_resp);
        end
        checks++;
        if (got_d.size() == 2 && (got_d[1] !== 32'h50000002 || got_s[1] !== 4'hC
                                  || got_l[1] !== 1'b1 || got_l[0] !== 1'b0)) begin
            errors++;
            $display("FAIL rstmid_data: beat1=%h strb=%h want 50000002/C", got_d[1], got_s[1]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_reject();
        test_err_resp();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
